// File: rtl/dircc_types_pkg.sv
// Shared DiRCC types: per-device state word, compute-scheduler FSM encoding
// and the timeout counter width.
package dircc_types_pkg;

  typedef logic [31:0] dircc_state_t;

  localparam int unsigned DIRCC_SCHED_CNT_W = 16;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_READ,
    SCHED_LOAD,
    SCHED_COMPUTE,
    SCHED_WRITE,
    SCHED_DONE
  } dircc_sched_state_t;

endpackage

// File: rtl/dircc_compute_scheduler.sv
// Sweeps every device slot of the state RAM through the compute handler.
// Optional build macro: DIRCC_SCHED_SKIP_UNCHANGED_EN suppresses write-back of unchanged state.
module dircc_compute_scheduler
  import dircc_types_pkg::*;
#(
  parameter int unsigned NUM_DEVICES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned IDX_W          = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         state_rd_en,
  output logic [IDX_W-1:0]             state_rd_addr,
  input  dircc_state_t                 state_rd_data,
  output dircc_state_t                 handler_read_state,
  output logic                         handler_start,
  input  dircc_state_t                 handler_write_state,
  input  logic                         handler_write_state_valid,
  output logic                         state_wr_en,
  output logic [IDX_W-1:0]             state_wr_addr,
  output dircc_state_t                 state_wr_data,
  output logic [DIRCC_SCHED_CNT_W-1:0] timeout_count
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DEVICES - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

  dircc_sched_state_t state;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   timer;
  logic               timed_out;
  logic               advance;

  // Outputs are registered, so each branch programs the strobes of the state it enters.
  always_comb begin
    timed_out = (state == SCHED_COMPUTE) && !handler_write_state_valid && (timer == LAST_TICK);
    advance   = (state == SCHED_WRITE) || timed_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= SCHED_IDLE;
      idx                <= '0;
      timer              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      state_rd_en        <= 1'b0;
      state_rd_addr      <= '0;
      handler_read_state <= '0;
      handler_start      <= 1'b0;
      state_wr_en        <= 1'b0;
      state_wr_addr      <= '0;
      state_wr_data      <= '0;
      timeout_count      <= '0;
    end else begin
      done          <= 1'b0;
      state_rd_en   <= 1'b0;
      state_wr_en   <= 1'b0;
      handler_start <= 1'b0;

      case (state)
        SCHED_IDLE: begin
          if (start) begin
            idx           <= '0;
            busy          <= 1'b1;
            state_rd_en   <= 1'b1;
            state_rd_addr <= '0;
            state         <= SCHED_READ;
          end
        end
        SCHED_READ: state <= SCHED_LOAD;
        SCHED_LOAD: begin
          handler_read_state <= state_rd_data;
          handler_start      <= 1'b1;
          timer              <= '0;
          state              <= SCHED_COMPUTE;
        end
        SCHED_COMPUTE: begin
          if (handler_write_state_valid) begin
`ifdef DIRCC_SCHED_SKIP_UNCHANGED_EN
            state_wr_en <= (handler_write_state != handler_read_state);
`else
            state_wr_en <= 1'b1;
`endif
            state_wr_addr <= idx;
            state_wr_data <= handler_write_state;
            state         <= SCHED_WRITE;
          end else if (timed_out) begin
            if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SCHED_WRITE: ;
        SCHED_DONE: begin
          busy  <= 1'b0;
          state <= SCHED_IDLE;
        end
        default: state <= SCHED_IDLE;
      endcase

      // Shared slot advance for the write-back and timeout exits of a slot.
      if (advance) begin
        if (idx == LAST_IDX) begin
          done  <= 1'b1;
          state <= SCHED_DONE;
        end else begin
          idx           <= idx + 1'b1;
          state_rd_en   <= 1'b1;
          state_rd_addr <= idx + 1'b1;
          state         <= SCHED_READ;
        end
      end
    end
  end

endmodule

// File: tb/tb_dircc_compute_scheduler.sv
// Scoreboard bench for dircc_compute_scheduler with a behavioural RAM and handler.
module tb_dircc_compute_scheduler;
  import dircc_types_pkg::*;

  localparam int N = 4;
  localparam int T = 8;
  localparam int AW = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done, state_rd_en, state_wr_en, handler_start;
  logic [AW-1:0]      state_rd_addr, state_wr_addr;
  dircc_state_t       state_rd_data = '0;
  dircc_state_t       handler_read_state, handler_write_state = '0, state_wr_data;
  logic               handler_write_state_valid = 1'b0;
  logic [15:0]        timeout_count;

  dircc_compute_scheduler #(.NUM_DEVICES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .state_rd_en(state_rd_en), .state_rd_addr(state_rd_addr), .state_rd_data(state_rd_data),
    .handler_read_state(handler_read_state), .handler_start(handler_start),
    .handler_write_state(handler_write_state),
    .handler_write_state_valid(handler_write_state_valid),
    .state_wr_en(state_wr_en), .state_wr_addr(state_wr_addr), .state_wr_data(state_wr_data),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_to = 0;

  typedef struct {int addr; dircc_state_t data;} wr_t;
  wr_t exp_wr[$];
  int  exp_rd[$];
  int  exp_done[$];

  dircc_state_t mem [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic report(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event not expected by scoreboard (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // State RAM: one-cycle read latency
  always @(posedge clk) begin
    if (state_rd_en) state_rd_data <= mem[state_rd_addr];
    if (state_wr_en) mem[state_wr_addr] <= state_wr_data;
  end

  // Handler model: answers read_state + h_inc after dly[slot] COMPUTE cycles, -1 = never
  int           dly [N];
  int           hs_slot = 0;
  dircc_state_t h_inc = '0;
  bit           idle_noise = 0;
  bit           h_active = 0;
  int           h_cnt = 0;
  int           h_delay = 0;

  always @(posedge clk) begin
    logic hv;
    #1;
    hv = 1'b0;
    if (!reset_n) h_active = 0;
    else if (handler_start) begin
      h_active = 1;
      h_cnt = 0;
      h_delay = (hs_slot < N) ? dly[hs_slot] : -1;
      hs_slot++;
    end else if (h_active) h_cnt++;
    if (h_active) begin
      if (h_delay == h_cnt) begin
        hv = 1'b1;
        h_active = 0;
      end else if (h_cnt == T - 1) h_active = 0;
      handler_write_state = handler_read_state + h_inc;
    end else if (idle_noise) begin
      hv = 1'($urandom_range(0, 1));
      handler_write_state = $urandom;
    end
    handler_write_state_valid = hv;
  end

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (state_rd_en) begin
        chk("rd_wr_exclusive", {63'd0, state_wr_en}, 64'd0);
        if (exp_rd.size() == 0) report("rd_unexpected");
        else chk("rd_addr", state_rd_addr, exp_rd.pop_front());
      end
      if (state_wr_en) begin
        if (exp_wr.size() == 0) report("wr_unexpected");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", state_wr_addr, w.addr);
          chk("wr_data", state_wr_data, w.data);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) report("done_unexpected");
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  // mode 0: valid first COMPUTE cycle, 1: never valid, 2: valid on last tick, else random
  task automatic run_sweep(input int mode, input dircc_state_t inc, input bit poke);
    int s = 0;
    int nto = 0;
    int d0;
    bit skip_eq = 0;
`ifdef DIRCC_SCHED_SKIP_UNCHANGED_EN
    skip_eq = 1;
`endif
    for (int i = 0; i < N; i++) begin
      int d;
      case (mode)
        0: d = 0;
        1: d = -1;
        2: d = T - 1;
        default: begin
          d = $urandom_range(0, T);
          if (d == T) d = -1;
        end
      endcase
      dly[i] = d;
      exp_rd.push_back(i);
      if (d < 0) begin
        s += 2 + T;
        nto++;
      end else begin
        s += 4 + d;
        if (!(skip_eq && inc == 0)) exp_wr.push_back('{i, mem[i] + inc});
      end
    end
    exp_to = (exp_to + nto > 65535) ? 65535 : exp_to + nto;
    h_inc = inc;
    hs_slot = 0;
    d0 = done_cnt;
    exp_done.push_back(cyc + s + 1);
    start = 1'b1;
    for (int c = 0; c < 2000 && done_cnt == d0; c++) begin
      @(posedge clk);
      #1;
      start = poke && (c == 3 || c == 7);
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      report("done_timeout");
      exp_done.delete();
    end
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("timeout_count", timeout_count, exp_to);
    chk("writes_outstanding", exp_wr.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 32'h10 + i;
    @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, state_rd_en, state_wr_en, handler_start,
                       state_rd_addr, state_wr_addr, timeout_count}, 64'd0);
    chk("reset_data", {handler_read_state, state_wr_data}, 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_sweep(0, 32'd1, 0);
    run_sweep(1, 32'd1, 0);
    run_sweep(2, 32'd5, 0);
    run_sweep(0, 32'd0, 1);

    idle_noise = 1;
    repeat (12) @(posedge clk);
    idle_noise = 0;
    @(posedge clk);
    #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    for (int k = 0; k < 6; k++) run_sweep(3, 32'($urandom_range(0, 3)), k[0]);

    // Reset while slot 2 is in COMPUTE
    dly[0] = 0; dly[1] = 0; dly[2] = -1; dly[3] = -1;
    for (int i = 0; i < 3; i++) exp_rd.push_back(i);
    for (int i = 0; i < 2; i++) exp_wr.push_back('{i, mem[i] + 32'd1});
    h_inc = 32'd1;
    hs_slot = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 100 && hs_slot < 3; c++) begin
      @(posedge clk);
      #2;
    end
    chk("reached_slot2", hs_slot, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("midsweep_reset_ctrl", {busy, done, state_rd_en, state_wr_en, handler_start,
                                state_rd_addr, state_wr_addr, timeout_count}, 64'd0);
    chk("midsweep_reset_data", {handler_read_state, state_wr_data}, 64'd0);
    exp_to = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    chk("partial_writes", exp_wr.size(), 0);
    chk("partial_reads", exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
    @(posedge clk);
    #1;
    run_sweep(0, 32'd1, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
